flag_hazard_ctrl: RTL and testbench

Controls the EX-stage NZCV status register for conditional branches (B.cond).
- Tracks in-flight flag-setting instructions (ADDS/SUBS/ANDS/ADDIS/SUBIS) from issue until commit.
- Drives the status register's update strobe.
- Stalls a B.cond in ID until its flags are available, or forwards them from the ALU.
- Issues a registered branch-resolution result to the fetch/PC logic.

---
 rtl/legv8_cond_pkg.sv | 47 ++++
 rtl/cond_eval.sv | 16 +
 rtl/flag_hazard_ctrl.sv | 98 +++++++++
 tb/tb_flag_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_cond_pkg.sv
// LEGv8 B.cond condition codes and their evaluation against NZCV.
// Shared by any block that needs to evaluate a condition code.
package legv8_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic logic cond_true(input logic [3:0] cond,
                                     input logic n, input logic z,
                                     input logic c, input logic v);
    logic r;
    unique case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_HS: r = c;
      COND_LO: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c & !z;
      COND_LS: r = !(c & !z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z & (n == v);
      COND_LE: r = !(!z & (n == v));
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: cond + NZCV -> taken.
// Kept standalone so CBZ/CSEL logic can reuse it.
module cond_eval
  import legv8_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken
);

  assign taken = cond_true(cond, n, z, c, v);

endmodule

// File: rtl/flag_hazard_ctrl.sv
// EX-stage NZCV hazard control: tracks in-flight flag writers, stalls or
// forwards for B.cond in ID, and registers the branch resolution.
module flag_hazard_ctrl #(
  parameter int FLAG_LAT = 2,
  parameter bit FORWARD  = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_sets_flags,
  input  logic             id_is_bcond,
  input  logic [3:0]       id_cond,
  input  logic             flush,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             sreg_n,
  input  logic             sreg_z,
  input  logic             sreg_c,
  input  logic             sreg_v,
  output logic             sreg_up,
  output logic             id_stall,
  output logic             id_fire,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  // Only the oldest writer (about to commit) is pending.
  localparam logic [FLAG_LAT:1] LAST_ONLY = FLAG_LAT'(1) << (FLAG_LAT - 1);

  logic [FLAG_LAT:1] pend;
  logic              use_alu;
  logic              flags_ok;
  logic              ev_n, ev_z, ev_c, ev_v;
  logic              taken;
  logic              bcond_fire;

  assign sreg_up  = pend[FLAG_LAT];
  assign use_alu  = FORWARD && (pend == LAST_ONLY);
  assign flags_ok = (pend == '0) || use_alu;

  assign id_stall = id_valid & id_is_bcond & ~flags_ok;
  // NOTE: pend is already clear in reset, but id_fire depends only on inputs
  // otherwise, so it is gated with rst_n to read 0 while reset is held.
  assign id_fire    = rst_n & id_valid & ~id_stall & ~flush;
  assign bcond_fire = id_fire & id_is_bcond;

  assign ev_n = use_alu ? alu_n : sreg_n;
  assign ev_z = use_alu ? alu_z : sreg_z;
  assign ev_c = use_alu ? alu_c : sreg_c;
  assign ev_v = use_alu ? alu_v : sreg_v;

  cond_eval u_cond_eval (
    .cond  (id_cond),
    .n     (ev_n),
    .z     (ev_z),
    .c     (ev_c),
    .v     (ev_v),
    .taken (taken)
  );

  // A B.cond that also sets flags is evaluated above against the prior
  // flags; its own writer enters pend[1] at this edge.
  // NOTE: non-blocking assignments keep every stage sampling the pre-edge
  // value, so the loop below shifts instead of rippling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = FLAG_LAT; i >= 2; i--) begin
        pend[i] <= flush ? 1'b0 : pend[i-1];
      end
      pend[1] <= id_fire & id_sets_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_valid <= bcond_fire;
      if (bcond_fire) br_taken <= taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Self-checking bench for flag_hazard_ctrl: one forwarding instance and one
// non-forwarding instance with a narrow counter for saturation.
module tb_flag_hazard_ctrl;
  import legv8_cond_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_a, id_valid_b;
  logic       id_sets_flags, id_is_bcond, flush;
  logic [3:0] id_cond;
  logic [3:0] alu_f, sreg_f;  // {n,z,c,v}

  logic        sreg_up_a, id_stall_a, id_fire_a, br_valid_a, br_taken_a;
  logic [15:0] stall_cnt_a;
  logic        sreg_up_b, id_stall_b, id_fire_b, br_valid_b, br_taken_b;
  logic [3:0]  stall_cnt_b;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_a[$];
  logic exp_b[$];

  always #5 clk = ~clk;

  flag_hazard_ctrl #(.FLAG_LAT(2), .FORWARD(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid_a), .id_sets_flags(id_sets_flags),
    .id_is_bcond(id_is_bcond), .id_cond(id_cond), .flush(flush),
    .alu_n(alu_f[3]), .alu_z(alu_f[2]), .alu_c(alu_f[1]), .alu_v(alu_f[0]),
    .sreg_n(sreg_f[3]), .sreg_z(sreg_f[2]), .sreg_c(sreg_f[1]), .sreg_v(sreg_f[0]),
    .sreg_up(sreg_up_a), .id_stall(id_stall_a), .id_fire(id_fire_a),
    .br_valid(br_valid_a), .br_taken(br_taken_a), .stall_cnt(stall_cnt_a)
  );

  flag_hazard_ctrl #(.FLAG_LAT(2), .FORWARD(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid_b), .id_sets_flags(id_sets_flags),
    .id_is_bcond(id_is_bcond), .id_cond(id_cond), .flush(flush),
    .alu_n(alu_f[3]), .alu_z(alu_f[2]), .alu_c(alu_f[1]), .alu_v(alu_f[0]),
    .sreg_n(sreg_f[3]), .sreg_z(sreg_f[2]), .sreg_c(sreg_f[1]), .sreg_v(sreg_f[0]),
    .sreg_up(sreg_up_b), .id_stall(id_stall_b), .id_fire(id_fire_b),
    .br_valid(br_valid_b), .br_taken(br_taken_b), .stall_cnt(stall_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic va, input logic vb, input logic sf,
                        input logic bc, input logic [3:0] cond);
    id_valid_a    = va;
    id_valid_b    = vb;
    id_sets_flags = sf;
    id_is_bcond   = bc;
    id_cond       = cond;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every resolved branch must match the oldest queued result.
  always @(negedge clk) begin
    if (br_valid_a) begin
      if (exp_a.size() == 0) check("br_a_spurious", 32'(br_valid_a), 0);
      else check("br_a_taken", 32'(br_taken_a), 32'(exp_a.pop_front()));
    end
    if (br_valid_b) begin
      if (exp_b.size() == 0) check("br_b_spurious", 32'(br_valid_b), 0);
      else check("br_b_taken", 32'(br_taken_b), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    alu_f = 4'b0000;
    sreg_f = 4'b0000;
    set_id(1'b1, 1'b1, 1'b0, 1'b0, COND_EQ);
    #2;
    check("rst_fire_a", 32'(id_fire_a), 0);
    check("rst_fire_b", 32'(id_fire_b), 0);
    check("rst_sreg_up", 32'(sreg_up_a), 0);
    check("rst_stall", 32'(id_stall_a), 0);
    check("rst_br_valid", 32'(br_valid_a), 0);
    check("rst_br_taken", 32'(br_taken_a), 0);
    check("rst_cnt", 32'(stall_cnt_a), 0);
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: no writers, Z=1: EQ taken, NE not taken.
    sreg_f = 4'b0100;
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_EQ);
    #1;
    check("s1_stall", 32'(id_stall_a), 0);
    check("s1_fire", 32'(id_fire_a), 1);
    exp_a.push_back(1'b1);
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_NE);
    #1;
    check("s1_br_valid_eq", 32'(br_valid_a), 1);
    check("s1_fire_ne", 32'(id_fire_a), 1);
    exp_a.push_back(1'b0);
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s1_br_valid_ne", 32'(br_valid_a), 1);
    next_cycle();
    check("s1_br_valid_idle", 32'(br_valid_a), 0);

    // 2: forwarding; sreg says GE true, live ALU says GE false.
    sreg_f = 4'b0000;
    alu_f  = 4'b1000;
    set_id(1'b1, 1'b0, 1'b1, 1'b0, COND_EQ);
    #1;
    check("s2_subs_fire", 32'(id_fire_a), 1);
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_GE);
    #1;
    check("s2_stall_t1", 32'(id_stall_a), 1);
    check("s2_fire_t1", 32'(id_fire_a), 0);
    check("s2_sreg_up_t1", 32'(sreg_up_a), 0);
    next_cycle();
    check("s2_cnt_t2", 32'(stall_cnt_a), 1);
    check("s2_sreg_up_t2", 32'(sreg_up_a), 1);
    check("s2_stall_t2", 32'(id_stall_a), 0);
    check("s2_fire_t2", 32'(id_fire_a), 1);
    exp_a.push_back(1'b0);
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s2_br_valid", 32'(br_valid_a), 1);
    check("s2_sreg_up_t3", 32'(sreg_up_a), 0);

    // 3: same stream on the non-forwarding instance.
    next_cycle();
    sreg_f = 4'b0000;
    alu_f  = 4'b1000;
    set_id(1'b0, 1'b1, 1'b1, 1'b0, COND_EQ);
    #1;
    check("s3_subs_fire", 32'(id_fire_b), 1);
    next_cycle();
    set_id(1'b0, 1'b1, 1'b0, 1'b1, COND_GE);
    #1;
    check("s3_stall_t1", 32'(id_stall_b), 1);
    next_cycle();
    check("s3_stall_t2", 32'(id_stall_b), 1);
    check("s3_sreg_up_t2", 32'(sreg_up_b), 1);
    next_cycle();
    sreg_f = alu_f;
    #1;
    check("s3_stall_t3", 32'(id_stall_b), 0);
    check("s3_fire_t3", 32'(id_fire_b), 1);
    check("s3_cnt_t3", 32'(stall_cnt_b), 2);
    exp_b.push_back(1'b0);
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s3_br_valid", 32'(br_valid_b), 1);

    // 4: flush kills the pending writer while a B.cond is stalled on it.
    next_cycle();
    sreg_f = 4'b1000;
    set_id(1'b1, 1'b0, 1'b1, 1'b0, COND_EQ);
    #1;
    check("s4_subs_fire", 32'(id_fire_a), 1);
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_MI);
    flush = 1'b1;
    #1;
    check("s4_flush_stall", 32'(id_stall_a), 1);
    check("s4_flush_fire", 32'(id_fire_a), 0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("s4_br_valid_after_flush", 32'(br_valid_a), 0);
    check("s4_sreg_up_killed", 32'(sreg_up_a), 0);
    check("s4_no_stall", 32'(id_stall_a), 0);
    check("s4_fire", 32'(id_fire_a), 1);
    check("s4_cnt", 32'(stall_cnt_a), 2);
    exp_a.push_back(1'b1);
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s4_br_valid", 32'(br_valid_a), 1);
    check("s4_sreg_up_t3", 32'(sreg_up_a), 0);

    // 5: two writers back to back, HI waits for the second to commit.
    next_cycle();
    sreg_f = 4'b0000;
    alu_f  = 4'b0000;
    set_id(1'b1, 1'b0, 1'b1, 1'b0, COND_EQ);
    next_cycle();
    #1;
    check("s5_adds2_fire", 32'(id_fire_a), 1);
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_HI);
    #1;
    check("s5_stall_t2", 32'(id_stall_a), 1);
    check("s5_sreg_up_t2", 32'(sreg_up_a), 1);
    next_cycle();
    sreg_f = alu_f;
    alu_f  = 4'b0010;
    #1;
    check("s5_stall_t3", 32'(id_stall_a), 0);
    check("s5_sreg_up_t3", 32'(sreg_up_a), 1);
    check("s5_fire_t3", 32'(id_fire_a), 1);
    check("s5_cnt", 32'(stall_cnt_a), 3);
    exp_a.push_back(1'b1);
    next_cycle();
    sreg_f = alu_f;
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s5_br_valid", 32'(br_valid_a), 1);
    check("s5_sreg_up_t4", 32'(sreg_up_a), 0);

    // 6: asynchronous reset with two writers in flight.
    next_cycle();
    set_id(1'b1, 1'b0, 1'b1, 1'b0, COND_EQ);
    next_cycle();
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_AL);
    #1;
    check("s6_stall_pre", 32'(id_stall_a), 1);
    check("s6_sreg_up_pre", 32'(sreg_up_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check("s6_rst_sreg_up", 32'(sreg_up_a), 0);
    check("s6_rst_stall", 32'(id_stall_a), 0);
    check("s6_rst_br_valid", 32'(br_valid_a), 0);
    check("s6_rst_br_taken", 32'(br_taken_a), 0);
    check("s6_rst_cnt_a", 32'(stall_cnt_a), 0);
    check("s6_rst_cnt_b", 32'(stall_cnt_b), 0);
    set_id(1'b1, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s6_rst_fire", 32'(id_fire_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check("s6_no_sreg_up", 32'(sreg_up_a), 0);
    end
    next_cycle();
    set_id(1'b1, 1'b0, 1'b0, 1'b1, COND_AL);
    #1;
    check("s6_al_fire", 32'(id_fire_a), 1);
    exp_a.push_back(1'b1);
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("s6_al_br_valid", 32'(br_valid_a), 1);

    // Counter saturation on the 4-bit instance: two stalls per B.cond.
    for (int k = 0; k < 11; k++) begin
      next_cycle();
      set_id(1'b0, 1'b1, 1'b1, 1'b1, COND_AL);
      #1;
      check("sat_cnt", 32'(stall_cnt_b), (2 * k > 15) ? 15 : 2 * k);
      check("sat_fire", 32'(id_fire_b), 1);
      exp_b.push_back(1'b1);
      next_cycle();
      check("sat_stall1", 32'(id_stall_b), 1);
      next_cycle();
      check("sat_stall2", 32'(id_stall_b), 1);
    end
    next_cycle();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, COND_EQ);
    #1;
    check("sat_final", 32'(stall_cnt_b), 15);

    repeat (3) next_cycle();
    check("sb_a_empty", 32'(exp_a.size()), 0);
    check("sb_b_empty", 32'(exp_b.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
